// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions used by the OAM DMA engine: the DMA state
// encoding, the $4014 trigger address and the OAMDATA register select.
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } oam_dma_state_e;

    localparam logic [15:0] OAM_DMA_ADDR    = 16'h4014;
    localparam logic [2:0]  PPU_OAMDATA_REG = 3'd4;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a write to $4014 halts the CPU and copies 256 bytes to OAMDATA.
// Define OAM_DMA_ALIGN_EN to add the get/put alignment cycle after the halt cycle.
module oam_dma
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    output logic        cpu_rdy_o,
    output logic        dma_busy_o,
    output logic [15:0] dma_addr_o,
    input  logic [7:0]  dma_data_i,
    output logic [2:0]  ppu_addr_o,
    output logic [7:0]  ppu_data_o,
    output logic        ppu_rw_o,
    output logic        ppu_ce_o
);

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    oam_dma_state_e state_q, state_d;
    logic           parity_q, parity_d;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     page_q, page_d;
    logic [7:0]     data_q, data_d;

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q ^ cpu_ce_i;
        idx_d    = idx_q;
        page_d   = page_q;
        data_d   = data_q;
        if (cpu_ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_we_i && (cpu_addr_i == OAM_DMA_ADDR)) begin
                        page_d  = cpu_data_i;
                        state_d = ST_HALT;
                    end
                end
                // A halt cycle that was a put cycle would leave READ on the wrong phase.
                ST_HALT:  state_d = (ALIGN_EN && parity_q) ? ST_ALIGN : ST_READ;
                ST_ALIGN: state_d = ST_READ;
                ST_READ: begin
                    data_d  = dma_data_i;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rdy_o  = (state_q == ST_IDLE);
        dma_busy_o = (state_q == ST_ALIGN) || (state_q == ST_READ) || (state_q == ST_WRITE);
        dma_addr_o = (state_q == ST_READ) ? {page_q, idx_q} : 16'h0000;
        ppu_addr_o = (state_q == ST_WRITE) ? PPU_OAMDATA_REG : 3'd0;
        ppu_data_o = (state_q == ST_WRITE) ? data_q : 8'h00;
        ppu_rw_o   = (state_q == ST_WRITE);
        ppu_ce_o   = (state_q == ST_WRITE) && cpu_ce_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            idx_q    <= 8'h00;
            page_q   <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed/randomised bench for oam_dma with a transfer-level reference model.
// Compile with OAM_DMA_ALIGN_EN defined to expect the alignment cycle.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic [15:0] cpu_addr_i = 16'h0000;
    logic [7:0]  cpu_data_i = 8'h00;
    logic        cpu_we_i = 1'b0;
    logic        cpu_rdy_o;
    logic        dma_busy_o;
    logic [15:0] dma_addr_o;
    logic [7:0]  dma_data_i;
    logic [2:0]  ppu_addr_o;
    logic [7:0]  ppu_data_o;
    logic        ppu_rw_o;
    logic        ppu_ce_o;

    logic [7:0]  mem [256];
    int          tests = 0;
    int          fails = 0;
    int          ce_cnt = 0;

    // Monitor-owned observation records
    logic [15:0] rd_q [$];
    logic [7:0]  wr_q [$];
    int          strobe_cnt = 0;
    int          rdy_low_cnt = 0;
    int          wide_cnt = 0;
    int          bad_reg_cnt = 0;
    logic        prev_ppu_ce = 1'b0;

    oam_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_rdy_o  (cpu_rdy_o),
        .dma_busy_o (dma_busy_o),
        .dma_addr_o (dma_addr_o),
        .dma_data_i (dma_data_i),
        .ppu_addr_o (ppu_addr_o),
        .ppu_data_o (ppu_data_o),
        .ppu_rw_o   (ppu_rw_o),
        .ppu_ce_o   (ppu_ce_o)
    );

    always #5 clk = ~clk;

    assign dma_data_i = mem[dma_addr_o[7:0]];

    always @(negedge clk) begin
        if (cpu_ce_i && !cpu_rdy_o) rdy_low_cnt++;
        if (cpu_ce_i && dma_busy_o && !ppu_rw_o) rd_q.push_back(dma_addr_o);
        if (ppu_ce_o) begin
            strobe_cnt++;
            wr_q.push_back(ppu_data_o);
            if (ppu_addr_o !== 3'd4 || ppu_rw_o !== 1'b1) bad_reg_cnt++;
            if (prev_ppu_ce) wide_cnt++;
        end
        prev_ppu_ce = ppu_ce_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: strobe for one clk, then 0..2 idle clks.
    task automatic cyc(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = a;
        cpu_data_i = d;
        @(posedge clk); #1;
        cpu_ce_i = 1'b0;
        cpu_we_i = 1'b0;
        ce_cnt++;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic filler();
        cyc(1'($urandom_range(0, 1)), 16'($urandom) & 16'h3FFF, 8'($urandom));
    endtask

    task automatic run_dma(input logic [7:0] page, input int trig_par, input bit linear,
                           input bit do_second, input bit do_pause, input string tag);
        int rd0, wr0, st0, rl0, n, exp_len, exp_rd, bad_rd, bad_wr, frz_bad, s0;
        int first_bad;
        logic [15:0] a0, exp_a;
        bit paused;
        for (int i = 0; i < 256; i++) mem[i] = linear ? i[7:0] : 8'($urandom);
        while ((ce_cnt % 2) != trig_par) filler();
        rd0 = rd_q.size();
        wr0 = wr_q.size();
        st0 = strobe_cnt;
        rl0 = rdy_low_cnt;
        cyc(1'b1, 16'h4014, page);
        chk({tag, "_halt_rdy"}, 32'(cpu_rdy_o), 32'd0);
        chk({tag, "_halt_busy"}, 32'(dma_busy_o), 32'd0);
        n = 0;
        paused = 1'b0;
        while (!cpu_rdy_o && n < 700) begin
            if (do_second && n == 100) cyc(1'b1, 16'h4014, ~page);
            else filler();
            n++;
            if (do_pause && !paused && n >= 200 && dma_busy_o && !ppu_rw_o
                && dma_addr_o[15:8] == page) begin
                paused = 1'b1;
                a0 = dma_addr_o;
                s0 = strobe_cnt;
                frz_bad = 0;
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk); #1;
                    if (dma_addr_o !== a0 || dma_busy_o !== 1'b1) frz_bad++;
                end
                chk({tag, "_pause_frozen"}, 32'(frz_bad), 32'd0);
                chk({tag, "_pause_strobes"}, 32'(strobe_cnt - s0), 32'd0);
            end
        end
        chk({tag, "_done"}, 32'(n < 700), 32'd1);
        if (do_pause) chk({tag, "_pause_hit"}, 32'(paused), 32'd1);
        exp_len = 513 + ((ALIGN && trig_par == 0) ? 1 : 0);
        chk({tag, "_len"}, 32'(rdy_low_cnt - rl0), 32'(exp_len));
        chk({tag, "_strobes"}, 32'(strobe_cnt - st0), 32'd256);
        exp_rd = 256 + ((ALIGN && trig_par == 0) ? 1 : 0);
        chk({tag, "_nreads"}, 32'(rd_q.size() - rd0), 32'(exp_rd));
        bad_rd = 0;
        bad_wr = 0;
        first_bad = -1;
        if (rd_q.size() >= 256 && wr_q.size() - wr0 >= 256) begin
            for (int i = 0; i < 256; i++) begin
                exp_a = {page, i[7:0]};
                if (rd_q[rd_q.size() - 256 + i] !== exp_a) begin
                    bad_rd++;
                    if (first_bad < 0) first_bad = i;
                end
                if (wr_q[wr0 + i] !== mem[i]) bad_wr++;
            end
        end else begin
            bad_rd = 256;
            bad_wr = 256;
        end
        chk({tag, "_read_addr_errs"}, 32'(bad_rd), 32'd0);
        chk({tag, "_oam_data_errs"}, 32'(bad_wr), 32'd0);
        chk({tag, "_rdy_after"}, 32'(cpu_rdy_o), 32'd1);
        chk({tag, "_busy_after"}, 32'(dma_busy_o), 32'd0);
    endtask

    initial begin
        int st0, st1, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(cpu_rdy_o), 32'd1);
        chk("rst_busy", 32'(dma_busy_o), 32'd0);
        chk("rst_dma_addr", 32'(dma_addr_o), 32'd0);
        chk("rst_ppu_addr", 32'(ppu_addr_o), 32'd0);
        chk("rst_ppu_data", 32'(ppu_data_o), 32'd0);
        chk("rst_ppu_rw", 32'(ppu_rw_o), 32'd0);
        chk("rst_ppu_ce", 32'(ppu_ce_o), 32'd0);
        rst_n = 1'b1;
        ce_cnt = 0;
        repeat (3) filler();

        run_dma(8'h02, 1, 1'b1, 1'b0, 1'b0, "get_aligned");
        run_dma(8'h02, 0, 1'b0, 1'b0, 1'b0, "put_aligned");
        run_dma(8'hC3, int'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, "second_wr");

        // Abort a transfer once 64 bytes have been written (idx = 8'h40)
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        st0 = strobe_cnt;
        cyc(1'b1, 16'h4014, 8'h55);
        n = 0;
        while ((strobe_cnt - st0) < 64 && n < 700) begin
            filler();
            n++;
        end
        chk("abort_reach_idx40", 32'(strobe_cnt - st0), 32'd64);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ce_cnt = 0;
        chk("abort_rdy", 32'(cpu_rdy_o), 32'd1);
        chk("abort_busy", 32'(dma_busy_o), 32'd0);
        chk("abort_dma_addr", 32'(dma_addr_o), 32'd0);
        chk("abort_ppu_rw", 32'(ppu_rw_o), 32'd0);
        st1 = strobe_cnt;
        repeat (20) filler();
        chk("abort_no_strobes", 32'(strobe_cnt - st1), 32'd0);
        chk("abort_still_idle", 32'(cpu_rdy_o), 32'd1);

        run_dma(8'($urandom_range(1, 255)), 1, 1'b0, 1'b0, 1'b0, "after_reset");

        chk("strobe_width", 32'(wide_cnt), 32'd0);
        chk("strobe_reg", 32'(bad_reg_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
